pc_control_fsm: RTL and testbench
=================================

Name: pc_control_fsm

Overview:
- Multi-cycle control unit that sequences the 16-bit processor through fetch, decode, execute, memory and writeback states.
- Issues the PC's control inputs every cycle: PCWrite, PC_isbranch, PC_set and branchType.
- Also issues the datapath strobes for memory, IR, register file and ALU.
- Acts as the driver of the PC interface; the PC unit responds to what this block issues.

Parameters:
- HALT_OPCODE, 4'hF: opcode that parks the FSM in HALT.
- MEM_TIMEOUT, 15: maximum wait cycles per memory access (MEM_WAIT_EN builds only); range 1..255.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- input_reset  input  1  synchronous, active-high reset.
- input_opcode  input  4  instruction bits [15:12], sampled in DECODE.
- input_mem_ready  input  1  memory handshake; used only in MEM_WAIT_EN builds, ignored otherwise.
- output_PCWrite  output  1  PC update enable.
- output_PC_isbranch  output  1  conditional update (PC uses zero/negative flags).
- output_PC_set  output  1  absolute jump; PC loads newPC*2.
- output_branchType  output  2  00 beq, 01 bne, 10 blt, 11 bge; equals input_opcode[1:0] during BRANCH, 00 otherwise.
- output_IRWrite / output_MemRead / output_MemWrite / output_RegWrite  output  1 each  datapath strobes.
- output_IorD  output  1  0 = address from PC, 1 = address from ALUOut.
- output_MemToReg  output  1  1 = writeback from MDR.
- output_ALUSrcA  output  1  0 = PC, 1 = register A.
- output_ALUSrcB  output  2  00 = B, 01 = constant 2, 10 = sign-extended immediate.
- output_ALUOp  output  2  00 = add, 01 = sub, 10 = funct field.
- output_illegal  output  1  one-cycle pulse on an undefined opcode.
- output_mem_timeout  output  1  one-cycle pulse on access abort (MEM_WAIT_EN only; 0 otherwise).
- output_state  output  4  current state encoding, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9, JUMP=10, HALT=11. Codes 12–15 are unreachable and recover to FETCH on the next edge.
- Outputs are Moore-decoded from state. Any output not listed for a state is 0.
- Reset: on the rising edge with input_reset=1, state becomes FETCH and the wait counter clears. While input_reset=1, all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) and pulses are forced to 0. Reset mid-access abandons the access with no PC or register write.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1 (plain increment, PC+2). Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10 (branch target precompute). Next state by opcode:
  - 0 → EXEC_R; 1 → EXEC_I
  - 2, 3 → MEM_ADDR
  - 4–7 → BRANCH; 8 → JUMP
  - HALT_OPCODE → HALT
  - anything else → FETCH, with output_illegal=1 in this cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_READ if opcode 2, MEM_WRITE if opcode 3. The opcode is latched in DECODE.
- MEM_READ: MemRead=1, IorD=1 → MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1 → FETCH.
- BRANCH: PCWrite=1, PC_isbranch=1, branchType=latched opcode[1:0], ALUSrcA=1, ALUSrcB=00, ALUOp=01 → FETCH.
- JUMP: PCWrite=1, PC_set=1 → FETCH.
- HALT: all outputs 0. Only reset exits.
- Instruction latency in cycles, fixed without MEM_WAIT_EN: R/I 4, LW 5, SW 4, branch 3, jump 3, illegal 2.
- PC_isbranch and PC_set are never both 1. Neither is ever 1 without PCWrite=1.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - FETCH, MEM_READ and MEM_WRITE hold their state and strobes until input_mem_ready=1.
  - PCWrite and IRWrite assert only in the FETCH cycle where input_mem_ready=1.
  - An 8-bit wait counter increments each stalled cycle and clears on state exit.
  - If the counter reaches MEM_TIMEOUT, output_mem_timeout pulses for one cycle and the state goes to FETCH. A FETCH timeout retries FETCH with no PC write.
- Not defined: input_mem_ready is ignored, every access takes exactly 1 cycle, and output_mem_timeout is constant 0.

Test Plan:
- Reset held 3 cycles, then released with opcode 0 → state sequence 0,1,2,4,0. PCWrite=1 only in the FETCH cycles. RegWrite=1 only in state 4.
- Opcode 2 → states 0,1,5,6,7. MemRead=1 and IorD=1 in state 6. RegWrite=1 and MemToReg=1 in state 7.
- Opcode 6 → BRANCH with PCWrite=1, PC_isbranch=1, branchType=10, PC_set=0, then FETCH.
- Opcode 8 → JUMP with PC_set=1, PCWrite=1. Opcode 4'hB → output_illegal=1 for exactly one cycle in DECODE, next state FETCH.
- Opcode 4'hF → HALT. Stays in state 11 for 20 cycles with all outputs 0. Reset then returns the FSM to FETCH.
- With MEM_WAIT_EN, MEM_TIMEOUT=4, and input_mem_ready held 0 in FETCH → state holds with PCWrite=0, then output_mem_timeout pulses once. With input_mem_ready=1 after 2 stall cycles → a single PCWrite pulse.

Source files
------------

// File: rtl/pc_control_fsm.sv
// Multi-cycle control unit for the 16-bit processor: sequences fetch/decode/execute/memory/writeback
// and drives the PC control inputs. Define MEM_WAIT_EN to add memory handshake stalls with timeout.
module pc_control_fsm #(
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       input_reset,
  input  logic [3:0] input_opcode,
  input  logic       input_mem_ready,
  output logic       output_PCWrite,
  output logic       output_PC_isbranch,
  output logic       output_PC_set,
  output logic [1:0] output_branchType,
  output logic       output_IRWrite,
  output logic       output_MemRead,
  output logic       output_MemWrite,
  output logic       output_RegWrite,
  output logic       output_IorD,
  output logic       output_MemToReg,
  output logic       output_ALUSrcA,
  output logic [1:0] output_ALUSrcB,
  output logic [1:0] output_ALUOp,
  output logic       output_illegal,
  output logic       output_mem_timeout,
  output logic [3:0] output_state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    ALU_WB    = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    MEM_WB    = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    HALT      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_isbranch;
    logic       pc_set;
    logic [1:0] branch_type;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word of a state; bt is only meaningful for BRANCH.
  function automatic ctrl_t decode_ctrl(state_t s, logic [1:0] bt);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      DECODE: c.alu_src_b = 2'b10;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      EXEC_I, MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ALU_WB: c.reg_write = 1'b1;
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      BRANCH: begin
        c.pc_write    = 1'b1;
        c.pc_isbranch = 1'b1;
        c.branch_type = bt;
        c.alu_src_a   = 1'b1;
        c.alu_op      = 2'b01;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_set   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic op_defined(logic [3:0] op);
    return (op <= 4'd8) || (op == HALT_OPCODE);
  endfunction

  function automatic state_t dispatch(logic [3:0] op);
    state_t n;
    case (op)
      4'd0:                   n = EXEC_R;
      4'd1:                   n = EXEC_I;
      4'd2, 4'd3:             n = MEM_ADDR;
      4'd4, 4'd5, 4'd6, 4'd7: n = BRANCH;
      4'd8:                   n = JUMP;
      default:                n = (op == HALT_OPCODE) ? HALT : FETCH;
    endcase
    return n;
  endfunction

  // done: memory access completes this cycle; abort: access timed out this cycle.
  function automatic state_t next_of(state_t s, logic [3:0] op, logic [3:0] op_q,
                                     logic done, logic abort);
    state_t n;
    case (s)
      FETCH:            n = (!abort && done) ? DECODE : FETCH;
      DECODE:           n = dispatch(op);
      EXEC_R, EXEC_I:   n = ALU_WB;
      MEM_ADDR:         n = (op_q == 4'd2) ? MEM_READ : (op_q == 4'd3) ? MEM_WRITE : FETCH;
      MEM_READ:         n = abort ? FETCH : done ? MEM_WB : MEM_READ;
      MEM_WRITE:        n = (abort || done) ? FETCH : MEM_WRITE;
      HALT:             n = HALT;
      default:          n = FETCH;
    endcase
    return n;
  endfunction

  state_t     state_reg;
  state_t     state_next;
  ctrl_t      ctrl_reg;
  logic [3:0] opcode_reg;
  logic       access_done;
  logic       access_abort;
  logic       fetch_gate;
  logic       run;

`ifdef MEM_WAIT_EN
  logic [7:0] wait_cnt_reg;
  logic       in_access;

  assign in_access    = state_reg inside {FETCH, MEM_READ, MEM_WRITE};
  assign access_done  = input_mem_ready;
  assign access_abort = in_access && !input_mem_ready && (wait_cnt_reg == 8'(MEM_TIMEOUT));
  // PC/IR may only update on the fetch cycle that actually returns the instruction.
  assign fetch_gate   = (state_reg != FETCH) || input_mem_ready;

  always_ff @(posedge CLK) begin
    if (input_reset || !in_access || input_mem_ready || access_abort) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end
`else
  logic unused_wait;

  assign access_done  = 1'b1;
  assign access_abort = 1'b0;
  assign fetch_gate   = 1'b1;
  assign unused_wait  = ^{input_mem_ready, MEM_TIMEOUT[0]};
`endif

  assign state_next = next_of(state_reg, input_opcode, opcode_reg, access_done, access_abort);

  // Control word is registered from the next state so it lines up with state_reg.
  // BRANCH is entered only from DECODE, so the live opcode supplies its branch type.
  always_ff @(posedge CLK) begin
    if (input_reset) begin
      state_reg  <= FETCH;
      ctrl_reg   <= decode_ctrl(FETCH, 2'b00);
      opcode_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_ctrl(state_next, input_opcode[1:0]);
      if (state_reg == DECODE) begin
        opcode_reg <= input_opcode;
      end
    end
  end

  assign run = !input_reset;

  assign output_PCWrite     = ctrl_reg.pc_write & fetch_gate & run;
  assign output_IRWrite     = ctrl_reg.ir_write & fetch_gate & run;
  assign output_PC_isbranch = ctrl_reg.pc_isbranch & run;
  assign output_PC_set      = ctrl_reg.pc_set & run;
  assign output_branchType  = ctrl_reg.branch_type;
  assign output_MemRead     = ctrl_reg.mem_read & run;
  assign output_MemWrite    = ctrl_reg.mem_write & run;
  assign output_RegWrite    = ctrl_reg.reg_write & run;
  assign output_IorD        = ctrl_reg.iord;
  assign output_MemToReg    = ctrl_reg.mem_to_reg;
  assign output_ALUSrcA     = ctrl_reg.alu_src_a;
  assign output_ALUSrcB     = ctrl_reg.alu_src_b;
  assign output_ALUOp       = ctrl_reg.alu_op;
  assign output_illegal     = run && (state_reg == DECODE) && !op_defined(input_opcode);
  assign output_mem_timeout = access_abort & run;
  assign output_state       = state_reg;

endmodule

// File: tb/tb_pc_control_fsm.sv
// Self-checking bench for pc_control_fsm: per-cycle expected state/control words are queued
// from an instruction-level model and popped against the DUT each cycle.
module tb_pc_control_fsm;

  logic       CLK = 1'b0;
  logic       input_reset;
  logic [3:0] input_opcode;
  logic       input_mem_ready;
  logic       output_PCWrite, output_PC_isbranch, output_PC_set;
  logic [1:0] output_branchType;
  logic       output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite;
  logic       output_IorD, output_MemToReg, output_ALUSrcA;
  logic [1:0] output_ALUSrcB, output_ALUOp;
  logic       output_illegal, output_mem_timeout;
  logic [3:0] output_state;

  always #5 CLK = ~CLK;

  pc_control_fsm #(.HALT_OPCODE(4'hF), .MEM_TIMEOUT(4)) dut (
    .CLK(CLK),
    .input_reset(input_reset),
    .input_opcode(input_opcode),
    .input_mem_ready(input_mem_ready),
    .output_PCWrite(output_PCWrite),
    .output_PC_isbranch(output_PC_isbranch),
    .output_PC_set(output_PC_set),
    .output_branchType(output_branchType),
    .output_IRWrite(output_IRWrite),
    .output_MemRead(output_MemRead),
    .output_MemWrite(output_MemWrite),
    .output_RegWrite(output_RegWrite),
    .output_IorD(output_IorD),
    .output_MemToReg(output_MemToReg),
    .output_ALUSrcA(output_ALUSrcA),
    .output_ALUSrcB(output_ALUSrcB),
    .output_ALUOp(output_ALUOp),
    .output_illegal(output_illegal),
    .output_mem_timeout(output_mem_timeout),
    .output_state(output_state)
  );

  typedef struct packed {
    logic       pcw;
    logic       isb;
    logic       set;
    logic [1:0] bt;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       rw;
    logic       iord;
    logic       mtr;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] op;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] state;
    ctrl_t      c;
    logic       illegal;
    logic       timeout;
  } obs_t;

  obs_t obs;
  assign obs = {output_state, output_PCWrite, output_PC_isbranch, output_PC_set, output_branchType,
                output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite, output_IorD,
                output_MemToReg, output_ALUSrcA, output_ALUSrcB, output_ALUOp,
                output_illegal, output_mem_timeout};

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Control table of each state as the datasheet lists it.
  function automatic ctrl_t spec_ctrl(int st, logic [1:0] bt);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.pcw = 1; c.irw = 1; c.mr = 1; c.sb = 2'b01; end
      1:  c.sb = 2'b10;
      2:  begin c.sa = 1; c.op = 2'b10; end
      3:  begin c.sa = 1; c.sb = 2'b10; end
      4:  c.rw = 1;
      5:  begin c.sa = 1; c.sb = 2'b10; end
      6:  begin c.mr = 1; c.iord = 1; end
      7:  begin c.rw = 1; c.mtr = 1; end
      8:  begin c.mw = 1; c.iord = 1; end
      9:  begin c.pcw = 1; c.isb = 1; c.bt = bt; c.sa = 1; c.op = 2'b01; end
      10: begin c.pcw = 1; c.set = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic obs_t spec_obs(int st, logic [1:0] bt, logic ill);
    obs_t o;
    o.state   = 4'(st);
    o.c       = spec_ctrl(st, bt);
    o.illegal = ill;
    o.timeout = 1'b0;
    return o;
  endfunction

  // Queue the per-cycle expectation of one instruction, starting at its FETCH.
  task automatic push_instr(input logic [3:0] op);
    logic ill;
    ill = !((op <= 4'd8) || (op == 4'hF));
    sb.push_back(spec_obs(0, 2'b00, 1'b0));
    sb.push_back(spec_obs(1, 2'b00, ill));
    case (op)
      4'd0:                   begin sb.push_back(spec_obs(2, 0, 0)); sb.push_back(spec_obs(4, 0, 0)); end
      4'd1:                   begin sb.push_back(spec_obs(3, 0, 0)); sb.push_back(spec_obs(4, 0, 0)); end
      4'd2:                   begin sb.push_back(spec_obs(5, 0, 0)); sb.push_back(spec_obs(6, 0, 0));
                                    sb.push_back(spec_obs(7, 0, 0)); end
      4'd3:                   begin sb.push_back(spec_obs(5, 0, 0)); sb.push_back(spec_obs(8, 0, 0)); end
      4'd4, 4'd5, 4'd6, 4'd7: sb.push_back(spec_obs(9, op[1:0], 0));
      4'd8:                   sb.push_back(spec_obs(10, 0, 0));
      4'hF:                   sb.push_back(spec_obs(11, 0, 0));
      default: ;
    endcase
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #2;
      checks++;
      if ({output_state, output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite, output_RegWrite,
           output_PC_isbranch, output_PC_set, output_illegal, output_mem_timeout} !== 13'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: state=%0d strobes=%b%b%b%b%b required state=0 strobes=00000",
                 i, output_state, output_PCWrite, output_IRWrite, output_MemRead, output_MemWrite,
                 output_RegWrite);
      end
    end
    input_reset = 1'b0;
  endtask

  task automatic test_alu();
    obs_t e;
    for (int k = 0; k < 2; k++) begin
      input_opcode = 4'(k);
      push_instr(input_opcode);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1; checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL alu op=%0d: got %h required %h", input_opcode, obs, e);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_mem();
    obs_t e;
    for (int k = 2; k < 4; k++) begin
      input_opcode = 4'(k);
      push_instr(input_opcode);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1; checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL mem op=%0d: got %h required %h", input_opcode, obs, e);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_branch_jump();
    obs_t e;
    for (int k = 4; k < 9; k++) begin
      input_opcode = 4'(k);
      push_instr(input_opcode);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1; checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL branch_jump op=%0d: got %h required %h", input_opcode, obs, e);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_illegal();
    obs_t e;
    for (int k = 9; k < 15; k++) begin
      input_opcode = 4'(k);
      push_instr(input_opcode);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1; checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL illegal op=%0d: got %h required %h", input_opcode, obs, e);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_halt();
    obs_t e;
    input_opcode = 4'hF;
    push_instr(input_opcode);
    for (int i = 0; i < 19; i++) sb.push_back(spec_obs(11, 2'b00, 1'b0));
    while (sb.size() != 0) begin
      e = sb.pop_front();
      #1; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL halt: got %h required %h", obs, e);
      end
      @(posedge CLK); #1;
    end
    input_reset = 1'b1;
    input_opcode = 4'd0;
    @(posedge CLK); #1;
    input_reset = 1'b0;
    #1; checks++;
    e = spec_obs(0, 2'b00, 1'b0);
    if (obs !== e) begin
      errors++;
      $display("FAIL halt_exit: got %h required %h", obs, e);
    end
    #1;
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait();
    obs_t e;
    obs_t stall;
    int   pcw_pulses;
    input_reset = 1'b1;
    @(posedge CLK); #1;
    input_reset = 1'b0;
    input_opcode = 4'd8;
    stall = spec_obs(0, 2'b00, 1'b0);
    stall.c.pcw = 1'b0;
    stall.c.irw = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(stall);
    e = stall; e.timeout = 1'b1;
    sb.push_back(e);
    sb.push_back(stall);
    sb.push_back(stall);
    push_instr(4'd8);
    pcw_pulses = 0;
    for (int i = 0; sb.size() != 0; i++) begin
      input_mem_ready = (i >= 7);
      e = sb.pop_front();
      #1; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mem_wait cycle %0d: got %h required %h", i, obs, e);
      end
      if (i < 8 && output_PCWrite) pcw_pulses++;
      @(posedge CLK); #1;
    end
    checks++;
    if (pcw_pulses !== 1) begin
      errors++;
      $display("FAIL mem_wait_pcwrite: got %0d fetch PCWrite pulses required 1", pcw_pulses);
    end
    input_mem_ready = 1'b1;
  endtask
`else
  task automatic test_ready_ignored();
    obs_t e;
    input_mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      input_opcode = 4'(3 - k);
      push_instr(input_opcode);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1; checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL ready_ignored op=%0d: got %h required %h", input_opcode, obs, e);
        end
        @(posedge CLK); #1;
      end
    end
    input_mem_ready = 1'b1;
  endtask
`endif

  task automatic test_back_to_back();
    obs_t e;
    for (int n = 0; n < 16; n++) begin
      input_opcode = 4'($urandom_range(0, 14));
      push_instr(input_opcode);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        #1; checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL back_to_back #%0d op=%0d: got %h required %h", n, input_opcode, obs, e);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  initial begin
    input_reset     = 1'b1;
    input_opcode    = 4'd0;
    input_mem_ready = 1'b1;
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_illegal();
    test_halt();
`ifdef MEM_WAIT_EN
    test_mem_wait();
`else
    test_ready_ignored();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
